// File: rtl/mempool_pkg.sv
// Shared types and constants for the read-only cache control register block.
package mempool_pkg;

    localparam int unsigned ROCacheNumAddrRules = 4;
    localparam int unsigned ROCacheAddrWidth    = 32;

    localparam logic [31:0] RegEnableOffset = 32'h0000_0000;
    localparam logic [31:0] RegFlushOffset  = 32'h0000_0004;
    localparam logic [31:0] RegStatusOffset = 32'h0000_0008;
    localparam logic [31:0] RegRuleBase     = 32'h0000_0010;

    typedef enum logic {
        StIdle,
        StFlush
    } flush_state_e;

    typedef struct packed {
        logic                                            enable;
        logic [ROCacheNumAddrRules*ROCacheAddrWidth-1:0] start_addr;
        logic [ROCacheNumAddrRules*ROCacheAddrWidth-1:0] end_addr;
        logic                                            flush_valid;
    } ro_cache_ctrl_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ro_cache_ctrl_regs_flush_fsm.sv
// Flush handshake towards the RO caches: one active flush plus one coalesced pending flush.
module ro_cache_flush_fsm
    import mempool_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trigger_i,
    input  logic done_clr_i,
    input  logic flush_ready_i,
    output logic flush_valid_o,
    output logic busy_o,
    output logic done_o
);

    flush_state_e state_q, state_d;
    logic         pending_q, pending_d;
    logic         done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = done_q;
        if (done_clr_i) done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trigger_i) state_d = StFlush;
            end
            StFlush: begin
                if (flush_ready_i) begin
                    // A set on the same cycle as a STATUS read must not be lost.
                    done_d = 1'b1;
                    if (pending_q || trigger_i) begin
                        pending_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (trigger_i) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign flush_valid_o = (state_q == StFlush);
    assign busy_o        = (state_q == StFlush) | pending_q;
    assign done_o        = done_q;

endmodule

// File: rtl/ro_cache_ctrl_regs.sv
// Register file and bus front-end generating the RO cache control bundle.
module ro_cache_ctrl_regs
    import mempool_pkg::*;
#(
    parameter int unsigned          NumAddrRules    = ROCacheNumAddrRules,
    parameter int unsigned          AddrWidth       = 32,
    parameter int unsigned          RegAddrWidth    = 8,
    parameter bit                   AutoFlush       = 1'b1,
    parameter logic [AddrWidth-1:0] Rule0StartReset = 32'h8000_0000,
    parameter logic [AddrWidth-1:0] Rule0EndReset   = 32'h8010_0000
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic                              req_write_i,
    input  logic [RegAddrWidth-1:0]           req_addr_i,
    input  logic [31:0]                       req_wdata_i,
    input  logic [3:0]                        req_strb_i,
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic [31:0]                       resp_rdata_o,
    output logic                              resp_error_o,
    output logic                              enable_o,
    output logic [NumAddrRules*AddrWidth-1:0] start_addr_o,
    output logic [NumAddrRules*AddrWidth-1:0] end_addr_o,
    output logic                              flush_valid_o,
    input  logic                              flush_ready_i,
    output logic                              busy_o
);

    localparam int unsigned IdxW = (NumAddrRules > 1) ? $clog2(NumAddrRules) : 1;

    logic                 enable_q;
    logic [AddrWidth-1:0] start_q [NumAddrRules];
    logic [AddrWidth-1:0] end_q   [NumAddrRules];
    logic                 resp_valid_q, resp_error_q;
    logic [31:0]          resp_rdata_q;

    logic [31:0]          addr_w, rule_off, rdata_d, rule_old, rule_new;
    logic                 is_enable, is_flush, is_status, is_rule, is_end, mapped;
    logic [IdxW-1:0]      rule_sel;
    logic                 accept, wr_en, trigger, done_clr, fsm_busy, fsm_done;

    assign accept = req_valid_i & req_ready_o;

    // Byte offsets within a word are ignored.
    assign addr_w    = 32'(req_addr_i) & 32'hFFFF_FFFC;
    assign rule_off  = addr_w - RegRuleBase;
    assign is_enable = (addr_w == RegEnableOffset);
    assign is_flush  = (addr_w == RegFlushOffset);
    assign is_status = (addr_w == RegStatusOffset);
    assign is_rule   = (addr_w >= RegRuleBase) && (rule_off[31:3] < 29'(NumAddrRules));
    assign is_end    = rule_off[2];
    assign rule_sel  = rule_off[3 +: IdxW];
    assign mapped    = is_enable | is_flush | is_status | is_rule;
    assign wr_en     = accept & req_write_i & mapped;

    always_comb begin
        rule_old = '0;
        if (is_rule) rule_old = is_end ? 32'(end_q[rule_sel]) : 32'(start_q[rule_sel]);
    end
    assign rule_new = apply_strb(rule_old, req_wdata_i, req_strb_i);

    always_comb begin
        trigger = 1'b0;
        if (wr_en) begin
            if (is_flush && req_strb_i[0] && req_wdata_i[0]) trigger = 1'b1;
            if (AutoFlush && is_rule) trigger = 1'b1;
            if (AutoFlush && is_enable && !enable_q && req_strb_i[0] && req_wdata_i[0]) begin
                trigger = 1'b1;
            end
        end
    end

    assign done_clr = accept & !req_write_i & is_status;

    always_comb begin
        rdata_d = '0;
        if (!req_write_i) begin
            if (is_enable)      rdata_d = {31'b0, enable_q};
            else if (is_status) rdata_d = {30'b0, fsm_done, fsm_busy};
            else if (is_rule)   rdata_d = rule_old;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
            for (int i = 0; i < int'(NumAddrRules); i++) begin
                start_q[i] <= (i == 0) ? Rule0StartReset : '0;
                end_q[i]   <= (i == 0) ? Rule0EndReset   : '0;
            end
        end else begin
            if (wr_en) begin
                if (is_enable && req_strb_i[0]) enable_q <= req_wdata_i[0];
                if (is_rule) begin
                    if (is_end) end_q[rule_sel]   <= AddrWidth'(rule_new);
                    else        start_q[rule_sel] <= AddrWidth'(rule_new);
                end
            end
            if (accept) begin
                resp_valid_q <= 1'b1;
                resp_error_q <= !mapped;
                resp_rdata_q <= rdata_d;
            end else if (resp_ready_i) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    ro_cache_flush_fsm u_flush_fsm (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .trigger_i     (trigger),
        .done_clr_i    (done_clr),
        .flush_ready_i (flush_ready_i),
        .flush_valid_o (flush_valid_o),
        .busy_o        (fsm_busy),
        .done_o        (fsm_done)
    );

    for (genvar i = 0; i < NumAddrRules; i++) begin : g_rule_out
        assign start_addr_o[i*AddrWidth +: AddrWidth] = start_q[i];
        assign end_addr_o[i*AddrWidth +: AddrWidth]   = end_q[i];
    end

    assign req_ready_o  = !resp_valid_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_error_o = resp_error_q;
    assign enable_o     = enable_q;
    assign busy_o       = fsm_busy;

endmodule

// File: tb/tb_ro_cache_ctrl_regs.sv
// Directed self-checking bench for ro_cache_ctrl_regs with default parameters.
module tb_ro_cache_ctrl_regs;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_write;
    logic [7:0]   req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_strb;
    logic         resp_valid, resp_ready, resp_error;
    logic [31:0]  resp_rdata;
    logic         enable;
    logic [127:0] start_addr, end_addr;
    logic         flush_valid, flush_ready, busy;

    int n_assert = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int hs0;
    logic [31:0] d;
    logic        e;

    always #5 clk = ~clk;

    ro_cache_ctrl_regs dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_write_i   (req_write),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_strb_i    (req_strb),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_rdata_o  (resp_rdata),
        .resp_error_o  (resp_error),
        .enable_o      (enable),
        .start_addr_o  (start_addr),
        .end_addr_o    (end_addr),
        .flush_valid_o (flush_valid),
        .flush_ready_i (flush_ready),
        .busy_o        (busy)
    );

    always @(posedge clk) begin
        if (rst_n && flush_valid && flush_ready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, output logic [31:0] rd, output logic err);
        int t;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_strb  = strb;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        t = 0;
        while (!resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!resp_valid) check("resp_valid_timeout", {31'b0, resp_valid}, 32'd1);
        rd = resp_rdata;
        err = resp_error;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic drain_flush();
        int t;
        @(negedge clk);
        flush_ready = 1'b1;
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        flush_ready = 1'b0;
        check("drain_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
        resp_ready = 1'b0; flush_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_flush_valid", {31'b0, flush_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        bus(1'b0, 8'h10, '0, 4'hF, d, e);
        check("rst_start0", d, 32'h8000_0000);
        check("rst_start0_err", {31'b0, e}, 32'd0);
        bus(1'b0, 8'h14, '0, 4'hF, d, e);
        check("rst_end0", d, 32'h8010_0000);
        bus(1'b0, 8'h00, '0, 4'hF, d, e);
        check("rst_enable", d, 32'h0);
        bus(1'b0, 8'h08, '0, 4'hF, d, e);
        check("rst_status", d, 32'h0);
        check("rst_flush_valid2", {31'b0, flush_valid}, 32'd0);

        // Byte strobes: only low half written
        bus(1'b1, 8'h18, 32'h8020_0000, 4'b0011, d, e);
        check("strb_partial", start_addr[63:32], 32'h0000_0000);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h18;
        req_wdata = 32'h8020_0000; req_strb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("strb_full_next_cycle", start_addr[63:32], 32'h8020_0000);
        check("resp_valid_next_cycle", {31'b0, resp_valid}, 32'd1);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        bus(1'b0, 8'h18, '0, 4'hF, d, e);
        check("start1_readback", d, 32'h8020_0000);
        check("rule_write_busy", {31'b0, busy}, 32'd1);
        drain_flush();
        bus(1'b0, 8'h08, '0, 4'hF, d, e);
        check("status_after_rule_flush", d, 32'h2);

        // Enable rising edge auto-flush
        bus(1'b1, 8'h00, 32'h1, 4'hF, d, e);
        check("en_enable", {31'b0, enable}, 32'd1);
        check("en_flush_valid", {31'b0, flush_valid}, 32'd1);
        check("en_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en_hold_valid", {31'b0, flush_valid}, 32'd1);
        end
        flush_ready = 1'b1;
        @(negedge clk);
        flush_ready = 1'b0;
        check("en_valid_dropped", {31'b0, flush_valid}, 32'd0);
        check("en_busy_dropped", {31'b0, busy}, 32'd0);
        bus(1'b0, 8'h08, '0, 4'hF, d, e);
        check("status_done", d, 32'h2);
        bus(1'b0, 8'h08, '0, 4'hF, d, e);
        check("status_cleared", d, 32'h0);
        bus(1'b1, 8'h00, 32'h1, 4'hF, d, e);
        check("en_already_set_no_flush", {31'b0, flush_valid}, 32'd0);

        // Coalesced triggers: exactly two handshakes
        hs0 = hs_cnt;
        bus(1'b1, 8'h04, 32'h1, 4'hF, d, e);
        bus(1'b1, 8'h04, 32'h1, 4'hF, d, e);
        bus(1'b1, 8'h20, 32'h9000_0000, 4'hF, d, e);
        check("coal_valid", {31'b0, flush_valid}, 32'd1);
        check("coal_busy", {31'b0, busy}, 32'd1);
        check("coal_rule_immediate", start_addr[95:64], 32'h9000_0000);
        @(negedge clk);
        flush_ready = 1'b1;
        @(negedge clk);
        flush_ready = 1'b0;
        check("coal_valid_after_hs1", {31'b0, flush_valid}, 32'd1);
        check("coal_busy_after_hs1", {31'b0, busy}, 32'd1);
        @(negedge clk);
        flush_ready = 1'b1;
        @(negedge clk);
        flush_ready = 1'b0;
        check("coal_valid_after_hs2", {31'b0, flush_valid}, 32'd0);
        check("coal_busy_after_hs2", {31'b0, busy}, 32'd0);
        check("coal_hs_count", 32'(hs_cnt - hs0), 32'd2);
        bus(1'b0, 8'h08, '0, 4'hF, d, e);
        check("coal_status", d, 32'h2);

        // Unmapped accesses
        bus(1'b0, 8'h40, '0, 4'hF, d, e);
        check("unmapped_rd_err", {31'b0, e}, 32'd1);
        check("unmapped_rd_data", d, 32'h0);
        bus(1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, d, e);
        check("unmapped_wr_err", {31'b0, e}, 32'd1);
        check("unmapped_wr_busy", {31'b0, busy}, 32'd0);
        check("unmapped_start0", start_addr[31:0], 32'h8000_0000);
        check("unmapped_start1", start_addr[63:32], 32'h8020_0000);
        check("unmapped_start2", start_addr[95:64], 32'h9000_0000);
        check("unmapped_start3", start_addr[127:96], 32'h0);
        check("unmapped_end0", end_addr[31:0], 32'h8010_0000);
        check("unmapped_end_rest", end_addr[127:32] == '0 ? 32'd0 : 32'd1, 32'd0);
        bus(1'b0, 8'h0C, '0, 4'hF, d, e);
        check("unmapped_0c_err", {31'b0, e}, 32'd1);

        // Response held under back-pressure
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_strb = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
            check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, 32'h8000_0000);
            check("bp_error", {31'b0, resp_error}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("bp_released_valid", {31'b0, resp_valid}, 32'd0);
        check("bp_released_ready", {31'b0, req_ready}, 32'd1);

        // Reset mid-flush with pending
        bus(1'b1, 8'h04, 32'h1, 4'hF, d, e);
        bus(1'b1, 8'h04, 32'h1, 4'hF, d, e);
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, flush_valid}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", {31'b0, flush_valid}, 32'd0);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("post_rst_enable", {31'b0, enable}, 32'd0);
        check("post_rst_start0", start_addr[31:0], 32'h8000_0000);
        check("post_rst_start1", start_addr[63:32], 32'h0);
        check("post_rst_start2", start_addr[95:64], 32'h0);
        check("post_rst_end0", end_addr[31:0], 32'h8010_0000);
        bus(1'b0, 8'h08, '0, 4'hF, d, e);
        check("post_rst_status", d, 32'h0);
        bus(1'b0, 8'h20, '0, 4'hF, d, e);
        check("post_rst_start2_rd", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
